// File: rtl/dev_tape_emulator.sv
// Device-side paper-tape emulator: host-preloaded characters feed the core's 5-bit input
// handshake, and characters the core emits are captured in a FIFO for the host to read back.
module dev_tape_emulator #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned IN_DELAY  = 8,
  parameter int unsigned OUT_DELAY = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          dev_input_rdy,
  output logic          dev_input_val,
  output logic [4:0]    dev_input_data,
  input  logic          dev_output_rdy,
  output logic          dev_output_ack,
  input  logic [4:0]    dev_output_data,
  input  logic          host_wr_en,
  input  logic [4:0]    host_wr_data,
  output logic          host_wr_full,
  input  logic          host_rd_en,
  output logic [4:0]    host_rd_data,
  output logic          host_rd_empty,
  output logic [CW-1:0] in_count,
  output logic [CW-1:0] out_count,
  output logic          out_overflow,
  input  logic          clr_overflow
);

  typedef enum logic [1:0] {I_IDLE, I_WAIT, I_PULSE, I_DONE} in_state_e;
  typedef enum logic [1:0] {O_IDLE, O_WAIT, O_ACK, O_DONE} out_state_e;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  // The counter is loaded on the request edge, so it holds DELAY-1 to land the pulse at t+DELAY.
  localparam logic [7:0] IN_LOAD  = (IN_DELAY == 0)  ? 8'd0 : 8'(IN_DELAY - 1);
  localparam logic [7:0] OUT_LOAD = (OUT_DELAY == 0) ? 8'd0 : 8'(OUT_DELAY - 1);

  logic [4:0] in_mem  [DEPTH];
  logic [4:0] out_mem [DEPTH];

  // Input channel state
  in_state_e     in_state_q, in_state_d;
  logic [7:0]    in_cnt_q, in_cnt_d;
  logic          in_val_q, in_val_d;
  logic [4:0]    in_data_q, in_data_d;
  logic [AW-1:0] in_wr_ptr_q, in_wr_ptr_d;
  logic [AW-1:0] in_rd_ptr_q, in_rd_ptr_d;
  logic [CW-1:0] in_count_q, in_count_d;
  logic          in_pop;
  logic          in_wr_ok;

  // Output channel state
  out_state_e    out_state_q, out_state_d;
  logic [7:0]    out_cnt_q, out_cnt_d;
  logic          out_ack_q, out_ack_d;
  logic [AW-1:0] out_wr_ptr_q, out_wr_ptr_d;
  logic [AW-1:0] out_rd_ptr_q, out_rd_ptr_d;
  logic [CW-1:0] out_count_q, out_count_d;
  logic          out_ovf_q, out_ovf_d;
  logic          out_push;
  logic          out_push_ok;
  logic          out_rd_ok;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    in_state_d = in_state_q;
    in_cnt_d   = in_cnt_q;
    in_val_d   = 1'b0;
    in_data_d  = in_data_q;
    in_pop     = 1'b0;
    case (in_state_q)
      I_IDLE: begin
        if (dev_input_rdy && (in_count_q != '0)) begin
          if (IN_DELAY == 0) begin
            in_pop = 1'b1;
          end else begin
            in_state_d = I_WAIT;
            in_cnt_d   = IN_LOAD;
          end
        end
      end
      I_WAIT: begin
        if (!dev_input_rdy)          in_state_d = I_IDLE;
        else if (in_cnt_q == 8'd0)   in_pop     = 1'b1;
        else                         in_cnt_d   = in_cnt_q - 8'd1;
      end
      I_PULSE: in_state_d = I_DONE;
      I_DONE: begin
        if (!dev_input_rdy) in_state_d = I_IDLE;
      end
      default: in_state_d = I_IDLE;
    endcase
    if (in_pop) begin
      in_state_d = I_PULSE;
      in_val_d   = 1'b1;
      in_data_d  = in_mem[in_rd_ptr_q];
    end
  end

  always_comb begin
    // Fullness is judged before the edge, so a write racing a pop on a full FIFO is dropped.
    in_wr_ok    = host_wr_en && (in_count_q != FULL_CNT);
    in_wr_ptr_d = in_wr_ptr_q + AW'(in_wr_ok);
    in_rd_ptr_d = in_rd_ptr_q + AW'(in_pop);
    in_count_d  = in_count_q + CW'(in_wr_ok) - CW'(in_pop);
  end

  always_comb begin
    out_state_d = out_state_q;
    out_cnt_d   = out_cnt_q;
    out_ack_d   = 1'b0;
    out_push    = 1'b0;
    case (out_state_q)
      O_IDLE: begin
        if (dev_output_rdy) begin
          if (OUT_DELAY == 0) begin
            out_push = 1'b1;
          end else begin
            out_state_d = O_WAIT;
            out_cnt_d   = OUT_LOAD;
          end
        end
      end
      O_WAIT: begin
        if (!dev_output_rdy)         out_state_d = O_IDLE;
        else if (out_cnt_q == 8'd0)  out_push    = 1'b1;
        else                         out_cnt_d   = out_cnt_q - 8'd1;
      end
      O_ACK: out_state_d = O_DONE;
      O_DONE: begin
        if (!dev_output_rdy) out_state_d = O_IDLE;
      end
      default: out_state_d = O_IDLE;
    endcase
    if (out_push) begin
      out_state_d = O_ACK;
      out_ack_d   = 1'b1;
    end
  end

  always_comb begin
    out_rd_ok    = host_rd_en && (out_count_q != '0);
    // A same-edge read frees the slot, so a capture into a full FIFO still lands.
    out_push_ok  = out_push && ((out_count_q != FULL_CNT) || out_rd_ok);
    out_wr_ptr_d = out_wr_ptr_q + AW'(out_push_ok);
    out_rd_ptr_d = out_rd_ptr_q + AW'(out_rd_ok);
    out_count_d  = out_count_q + CW'(out_push_ok) - CW'(out_rd_ok);
    if (clr_overflow) out_ovf_d = 1'b0;
    else              out_ovf_d = out_ovf_q | (out_push && !out_push_ok);
  end

  // NOTE: storage has no reset; the occupancy counters alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (in_wr_ok)    in_mem[in_wr_ptr_q]   <= host_wr_data;
    if (out_push_ok) out_mem[out_wr_ptr_q] <= dev_output_data;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      in_state_q   <= I_IDLE;
      in_cnt_q     <= 8'd0;
      in_val_q     <= 1'b0;
      in_data_q    <= 5'd0;
      in_wr_ptr_q  <= '0;
      in_rd_ptr_q  <= '0;
      in_count_q   <= '0;
      out_state_q  <= O_IDLE;
      out_cnt_q    <= 8'd0;
      out_ack_q    <= 1'b0;
      out_wr_ptr_q <= '0;
      out_rd_ptr_q <= '0;
      out_count_q  <= '0;
      out_ovf_q    <= 1'b0;
    end else begin
      in_state_q   <= in_state_d;
      in_cnt_q     <= in_cnt_d;
      in_val_q     <= in_val_d;
      in_data_q    <= in_data_d;
      in_wr_ptr_q  <= in_wr_ptr_d;
      in_rd_ptr_q  <= in_rd_ptr_d;
      in_count_q   <= in_count_d;
      out_state_q  <= out_state_d;
      out_cnt_q    <= out_cnt_d;
      out_ack_q    <= out_ack_d;
      out_wr_ptr_q <= out_wr_ptr_d;
      out_rd_ptr_q <= out_rd_ptr_d;
      out_count_q  <= out_count_d;
      out_ovf_q    <= out_ovf_d;
    end
  end

  assign dev_input_val  = in_val_q;
  assign dev_input_data = in_data_q;
  assign dev_output_ack = out_ack_q;
  assign host_wr_full   = (in_count_q == FULL_CNT);
  assign host_rd_empty  = (out_count_q == '0);
  assign host_rd_data   = (out_count_q != '0) ? out_mem[out_rd_ptr_q] : 5'd0;
  assign in_count       = in_count_q;
  assign out_count      = out_count_q;
  assign out_overflow   = out_ovf_q;

endmodule

// File: tb/tb_dev_tape_emulator.sv
// Bench for dev_tape_emulator: FIFO contents and overflow kept as queues, pulse timing
// predicted from the request cycle plus the configured delay.
module tb_dev_tape_emulator;
  localparam int DEPTH     = 16;
  localparam int IN_DELAY  = 8;
  localparam int OUT_DELAY = 5;
  localparam int CW        = $clog2(DEPTH) + 1;
  localparam int Z_DEPTH   = 4;
  localparam int ZCW       = $clog2(Z_DEPTH) + 1;
  localparam logic [4:0] ZC [2] = '{5'h03, 5'h1C};

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic          dev_input_rdy = 1'b0, dev_output_rdy = 1'b0;
  logic          host_wr_en = 1'b0, host_rd_en = 1'b0, clr_overflow = 1'b0;
  logic [4:0]    dev_output_data = 5'd0, host_wr_data = 5'd0;
  logic          dev_input_val, dev_output_ack, host_wr_full, host_rd_empty, out_overflow;
  logic [4:0]    dev_input_data, host_rd_data;
  logic [CW-1:0] in_count, out_count;

  logic           z_dev_input_rdy = 1'b0, z_dev_output_rdy = 1'b0;
  logic           z_host_wr_en = 1'b0, z_host_rd_en = 1'b0;
  logic [4:0]     z_dev_output_data = 5'd0, z_host_wr_data = 5'd0;
  logic           z_dev_input_val, z_dev_output_ack, z_host_wr_full, z_host_rd_empty, z_out_overflow;
  logic [4:0]     z_dev_input_data, z_host_rd_data;
  logic [ZCW-1:0] z_in_count, z_out_count;

  dev_tape_emulator #(.DEPTH(DEPTH), .IN_DELAY(IN_DELAY), .OUT_DELAY(OUT_DELAY)) u_dut (
    .clk(clk), .resetn(resetn),
    .dev_input_rdy(dev_input_rdy), .dev_input_val(dev_input_val), .dev_input_data(dev_input_data),
    .dev_output_rdy(dev_output_rdy), .dev_output_ack(dev_output_ack), .dev_output_data(dev_output_data),
    .host_wr_en(host_wr_en), .host_wr_data(host_wr_data), .host_wr_full(host_wr_full),
    .host_rd_en(host_rd_en), .host_rd_data(host_rd_data), .host_rd_empty(host_rd_empty),
    .in_count(in_count), .out_count(out_count), .out_overflow(out_overflow),
    .clr_overflow(clr_overflow)
  );

  dev_tape_emulator #(.DEPTH(Z_DEPTH), .IN_DELAY(0), .OUT_DELAY(0)) u_dut_zero (
    .clk(clk), .resetn(resetn),
    .dev_input_rdy(z_dev_input_rdy), .dev_input_val(z_dev_input_val), .dev_input_data(z_dev_input_data),
    .dev_output_rdy(z_dev_output_rdy), .dev_output_ack(z_dev_output_ack), .dev_output_data(z_dev_output_data),
    .host_wr_en(z_host_wr_en), .host_wr_data(z_host_wr_data), .host_wr_full(z_host_wr_full),
    .host_rd_en(z_host_rd_en), .host_rd_data(z_host_rd_data), .host_rd_empty(z_host_rd_empty),
    .in_count(z_in_count), .out_count(z_out_count), .out_overflow(z_out_overflow),
    .clr_overflow(1'b0)
  );

  int errors = 0;
  int checks = 0;

  // Reference model of the main instance
  logic [4:0] in_q[$];
  logic [4:0] out_q[$];
  bit         ovf_exp = 1'b0;

  task automatic host_write(input logic [4:0] d);
    host_wr_en = 1'b1; host_wr_data = d;
    @(negedge clk);
    host_wr_en = 1'b0;
    if (in_q.size() < DEPTH) in_q.push_back(d);
    checks++;
    if (in_count !== CW'(in_q.size())) begin errors++; $display("FAIL wr_in_count: got %0d expected %0d", in_count, in_q.size()); end
    checks++;
    if (host_wr_full !== (in_q.size() == DEPTH)) begin errors++; $display("FAIL wr_full: got %0b expected %0b", host_wr_full, in_q.size() == DEPTH); end
  endtask

  task automatic host_read();
    logic [4:0] exp_d;
    if (out_q.size() == 0) begin
      checks++;
      if (host_rd_empty !== 1'b1 || host_rd_data !== 5'd0) begin errors++; $display("FAIL rd_empty_state: got empty=%0b data=%0h expected empty=1 data=0", host_rd_empty, host_rd_data); end
      host_rd_en = 1'b1; @(negedge clk); host_rd_en = 1'b0;
      checks++;
      if (out_count !== '0) begin errors++; $display("FAIL rd_empty_count: got %0d expected 0", out_count); end
    end else begin
      exp_d = out_q.pop_front();
      checks++;
      if (host_rd_data !== exp_d || host_rd_empty !== 1'b0) begin errors++; $display("FAIL rd_data: got %0h (empty=%0b) expected %0h", host_rd_data, host_rd_empty, exp_d); end
      host_rd_en = 1'b1; @(negedge clk); host_rd_en = 1'b0;
      checks++;
      if (out_count !== CW'(out_q.size())) begin errors++; $display("FAIL rd_out_count: got %0d expected %0d", out_count, out_q.size()); end
    end
  endtask

  // One input request; optionally a host write lands on the same edge as the pop.
  task automatic in_xfer(input bit wr_at_pop, input logic [4:0] wd);
    int k = 0;
    bit seen = 1'b0;
    bit room;
    logic [4:0] exp_d;
    dev_input_rdy = 1'b1;
    while (!seen && k < 400) begin
      if (wr_at_pop && k == IN_DELAY) begin host_wr_en = 1'b1; host_wr_data = wd; end
      @(negedge clk);
      host_wr_en = 1'b0;
      k++;
      seen = dev_input_val;
    end
    checks++;
    if (!seen || k != IN_DELAY + 1) begin errors++; $display("FAIL in_latency: got %0d cycles (seen=%0b) expected %0d", k, seen, IN_DELAY + 1); end
    if (seen && in_q.size() > 0) begin
      room  = in_q.size() < DEPTH;
      exp_d = in_q.pop_front();
      if (wr_at_pop && room) in_q.push_back(wd);
      checks++;
      if (dev_input_data !== exp_d) begin errors++; $display("FAIL in_data: got %0h expected %0h", dev_input_data, exp_d); end
    end
    checks++;
    if (in_count !== CW'(in_q.size())) begin errors++; $display("FAIL in_count_after_pop: got %0d expected %0d", in_count, in_q.size()); end
    @(negedge clk);
    checks++;
    if (dev_input_val !== 1'b0) begin errors++; $display("FAIL in_val_width: got %0b expected 0", dev_input_val); end
    dev_input_rdy = 1'b0;
    @(negedge clk);
  endtask

  // One output request; optionally a host read or an overflow clear lands on the capture edge.
  task automatic out_xfer(input logic [4:0] d, input bit rd_at_cap, input bit clr_at_cap);
    int k = 0;
    bit seen = 1'b0;
    dev_output_rdy = 1'b1; dev_output_data = d;
    while (!seen && k < 400) begin
      if (k == OUT_DELAY) begin
        if (rd_at_cap && out_q.size() > 0) begin
          checks++;
          if (host_rd_data !== out_q[0]) begin errors++; $display("FAIL cap_rd_data: got %0h expected %0h", host_rd_data, out_q[0]); end
          host_rd_en = 1'b1;
        end
        clr_overflow = clr_at_cap;
      end
      @(negedge clk);
      host_rd_en = 1'b0; clr_overflow = 1'b0;
      k++;
      seen = dev_output_ack;
    end
    checks++;
    if (!seen || k != OUT_DELAY + 1) begin errors++; $display("FAIL out_latency: got %0d cycles (seen=%0b) expected %0d", k, seen, OUT_DELAY + 1); end
    if (rd_at_cap && out_q.size() > 0) void'(out_q.pop_front());
    if (out_q.size() < DEPTH) out_q.push_back(d);
    else                      ovf_exp = 1'b1;
    if (clr_at_cap) ovf_exp = 1'b0;
    checks++;
    if (out_count !== CW'(out_q.size())) begin errors++; $display("FAIL out_count: got %0d expected %0d", out_count, out_q.size()); end
    checks++;
    if (out_overflow !== ovf_exp) begin errors++; $display("FAIL out_overflow: got %0b expected %0b", out_overflow, ovf_exp); end
    @(negedge clk);
    checks++;
    if (dev_output_ack !== 1'b0) begin errors++; $display("FAIL out_ack_width: got %0b expected 0", dev_output_ack); end
    dev_output_rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (dev_input_val !== 1'b0 || dev_input_data !== 5'd0 || dev_output_ack !== 1'b0) begin
      errors++; $display("FAIL %s_dev: got val=%0b data=%0h ack=%0b expected 0/0/0", tag, dev_input_val, dev_input_data, dev_output_ack);
    end
    checks++;
    if (host_wr_full !== 1'b0 || host_rd_empty !== 1'b1 || host_rd_data !== 5'd0) begin
      errors++; $display("FAIL %s_host: got full=%0b empty=%0b rd_data=%0h expected 0/1/0", tag, host_wr_full, host_rd_empty, host_rd_data);
    end
    checks++;
    if (in_count !== '0 || out_count !== '0 || out_overflow !== 1'b0) begin
      errors++; $display("FAIL %s_counts: got in=%0d out=%0d ovf=%0b expected 0/0/0", tag, in_count, out_count, out_overflow);
    end
    checks++;
    if (z_in_count !== '0 || z_out_count !== '0 || z_host_rd_empty !== 1'b1 || z_dev_input_data !== 5'd0) begin
      errors++; $display("FAIL %s_zero_inst: got in=%0d out=%0d empty=%0b data=%0h expected 0/0/1/0", tag, z_in_count, z_out_count, z_host_rd_empty, z_dev_input_data);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_input_basic();
    host_write(5'h05); host_write(5'h1A); host_write(5'h1F);
    checks++;
    if (in_count !== CW'(3)) begin errors++; $display("FAIL preload_count: got %0d expected 3", in_count); end
    repeat (3) in_xfer(1'b0, 5'd0);
    checks++;
    if (in_count !== '0) begin errors++; $display("FAIL drained_count: got %0d expected 0", in_count); end
  endtask

  task automatic test_input_empty_wait();
    int nval = 0;
    int k = 0;
    bit seen = 1'b0;
    dev_input_rdy = 1'b1;
    repeat (20) begin @(negedge clk); if (dev_input_val) nval++; end
    checks++;
    if (nval != 0) begin errors++; $display("FAIL empty_no_val: got %0d pulses expected 0", nval); end
    host_wr_en = 1'b1; host_wr_data = 5'h11;
    @(negedge clk);
    host_wr_en = 1'b0;
    in_q.push_back(5'h11);
    checks++;
    if (in_count !== CW'(1)) begin errors++; $display("FAIL late_write_count: got %0d expected 1", in_count); end
    while (!seen && k < 400) begin @(negedge clk); k++; seen = dev_input_val; end
    checks++;
    if (!seen || k != IN_DELAY + 1) begin errors++; $display("FAIL late_latency: got %0d cycles (seen=%0b) expected %0d", k, seen, IN_DELAY + 1); end
    checks++;
    if (dev_input_data !== 5'h11) begin errors++; $display("FAIL late_data: got %0h expected 11", dev_input_data); end
    void'(in_q.pop_front());
    @(negedge clk);
    host_write(5'h07);
    nval = 0;
    repeat (30) begin @(negedge clk); if (dev_input_val) nval++; end
    checks++;
    if (nval != 0 || in_count !== CW'(1)) begin errors++; $display("FAIL no_repeat: got %0d pulses count=%0d expected 0 pulses count=1", nval, in_count); end
    dev_input_rdy = 1'b0;
    @(negedge clk);
    in_xfer(1'b0, 5'd0);
  endtask

  task automatic test_input_full();
    for (int i = 0; i < DEPTH + 3; i++) host_write(5'($urandom));
    checks++;
    if (in_count !== CW'(DEPTH) || host_wr_full !== 1'b1) begin errors++; $display("FAIL fill: got count=%0d full=%0b expected %0d/1", in_count, host_wr_full, DEPTH); end
    in_xfer(1'b1, 5'h0E);
    in_xfer(1'b1, 5'h15);
    while (in_q.size() > 0) in_xfer(1'b0, 5'd0);
  endtask

  task automatic test_zero_delay();
    int k;
    bit seen;
    for (int i = 0; i < 2; i++) begin
      z_dev_output_rdy = 1'b1; z_dev_output_data = ZC[i]; k = 0; seen = 1'b0;
      while (!seen && k < 50) begin @(negedge clk); k++; seen = z_dev_output_ack; end
      checks++;
      if (!seen || k != 1) begin errors++; $display("FAIL z_out_latency: got %0d cycles (seen=%0b) expected 1", k, seen); end
      @(negedge clk);
      checks++;
      if (z_dev_output_ack !== 1'b0) begin errors++; $display("FAIL z_ack_width: got %0b expected 0", z_dev_output_ack); end
      z_dev_output_rdy = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (z_out_count !== ZCW'(2)) begin errors++; $display("FAIL z_out_count: got %0d expected 2", z_out_count); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (z_host_rd_data !== ZC[i]) begin errors++; $display("FAIL z_rd_data: got %0h expected %0h", z_host_rd_data, ZC[i]); end
      z_host_rd_en = 1'b1; @(negedge clk); z_host_rd_en = 1'b0;
    end
    checks++;
    if (z_host_rd_empty !== 1'b1) begin errors++; $display("FAIL z_rd_empty: got %0b expected 1", z_host_rd_empty); end
    z_host_wr_en = 1'b1; z_host_wr_data = 5'h0A;
    @(negedge clk);
    z_host_wr_en = 1'b0;
    z_dev_input_rdy = 1'b1; k = 0; seen = 1'b0;
    while (!seen && k < 50) begin @(negedge clk); k++; seen = z_dev_input_val; end
    checks++;
    if (!seen || k != 1 || z_dev_input_data !== 5'h0A) begin errors++; $display("FAIL z_input: got cycles=%0d data=%0h expected 1/0a", k, z_dev_input_data); end
    @(negedge clk);
    z_dev_input_rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_output_overflow();
    while (out_q.size() > 0) host_read();
    for (int i = 0; i < DEPTH + 1; i++) out_xfer(5'($urandom), 1'b0, 1'b0);
    clr_overflow = 1'b1; @(negedge clk); clr_overflow = 1'b0;
    ovf_exp = 1'b0;
    checks++;
    if (out_overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow: got %0b expected 0", out_overflow); end
    out_xfer(5'($urandom), 1'b1, 1'b0);
    out_xfer(5'($urandom), 1'b0, 1'b1);
    while (out_q.size() > 0) host_read();
    host_read();
  endtask

  task automatic test_input_abort();
    int nval = 0;
    host_write(5'h13);
    dev_input_rdy = 1'b1;
    repeat (3) @(negedge clk);
    dev_input_rdy = 1'b0;
    repeat (IN_DELAY + 8) begin @(negedge clk); if (dev_input_val) nval++; end
    checks++;
    if (nval != 0 || in_count !== CW'(in_q.size())) begin errors++; $display("FAIL abort: got %0d pulses count=%0d expected 0 pulses count=%0d", nval, in_count, in_q.size()); end
    in_xfer(1'b0, 5'd0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0, 1: host_write(5'($urandom));
        2: if (in_q.size() > 0) in_xfer(1'b0, 5'd0);
        3: out_xfer(5'($urandom), 1'b0, 1'b0);
        default: host_read();
      endcase
    end
  endtask

  task automatic test_reset_midflight();
    int nack = 0;
    while (in_q.size() > 0) in_xfer(1'b0, 5'd0);
    host_write(5'h0D);
    in_xfer(1'b0, 5'd0);
    host_write(5'h09);
    out_xfer(5'h15, 1'b0, 1'b0);
    dev_output_rdy = 1'b1; dev_output_data = 5'h16;
    repeat (2) @(negedge clk);
    #2 resetn = 1'b0;
    #1 check_reset_values("async_reset");
    repeat (OUT_DELAY + 3) begin @(negedge clk); if (dev_output_ack) nack++; end
    checks++;
    if (nack != 0) begin errors++; $display("FAIL reset_no_ack: got %0d acks expected 0", nack); end
    dev_output_rdy = 1'b0;
    resetn = 1'b1;
    in_q.delete(); out_q.delete(); ovf_exp = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("after_reset");
    out_xfer(5'h1E, 1'b0, 1'b0);
    host_read();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_input_basic();
    test_input_empty_wait();
    test_input_full();
    test_zero_delay();
    test_output_overflow();
    test_input_abort();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
